// File: rtl/fsm1_route_core_pkg.sv
// Shared definitions for the fsm1_route_core slice.
//   - state_e                : 2-bit Moore state encoding (S0..S3)
//   - ENC_S0..ENC_S3         : raw bit patterns of each state
//   - CLK_EDGE_ONLY_DEFAULT  : default for the top-level CLK_EDGE_ONLY parameter
//   - is_s3()                : helper decode used by the output logic
package fsm1_route_core_pkg;

    localparam logic [1:0] ENC_S0 = 2'b00;
    localparam logic [1:0] ENC_S1 = 2'b01;
    localparam logic [1:0] ENC_S2 = 2'b10;
    localparam logic [1:0] ENC_S3 = 2'b11;

    typedef enum logic [1:0] {
        S0 = ENC_S0,
        S1 = ENC_S1,
        S2 = ENC_S2,
        S3 = ENC_S3
    } state_e;

    // Nonzero: every state update happens on the rising edge of GCLK_Pad.
    localparam int CLK_EDGE_ONLY_DEFAULT = 1;

    function automatic logic is_s3(input state_e st);
        return (st == S3);
    endfunction

endpackage

// File: rtl/fsm1_route_core_if.sv
// Pad-level bundle between the route core and its environment.
//   input1_Pad / input2_Pad         : event pulses into the core
//   state_obs0_Pad / state_obs1_Pad : current state bits (LSB / MSB)
//   output1_Pad                     : high while the FSM sits in S3
// master drives the events and observes; slave is the core side.
interface fsm1_route_core_if;

    logic input1_Pad;
    logic input2_Pad;
    logic state_obs0_Pad;
    logic state_obs1_Pad;
    logic output1_Pad;

    modport master (
        output input1_Pad,
        output input2_Pad,
        input  state_obs0_Pad,
        input  state_obs1_Pad,
        input  output1_Pad
    );

    modport slave (
        input  input1_Pad,
        input  input2_Pad,
        output state_obs0_Pad,
        output state_obs1_Pad,
        output output1_Pad
    );

endinterface

// File: rtl/fsm1_pulse_capture.sv
// Captures a short asynchronous pulse so it is seen at the next clock edge.
//   clk_i   : core clock (active edge chosen by the top)
//   rst_i   : asynchronous active-high clear of both flops
//   pad_i   : event pad; only its rising edge matters
//   pend_o  : high from an event's rising edge until the next clock edge
// The pad edge clocks a toggle flop; the clock domain keeps an acknowledge
// copy. They differ exactly while an event is pending, and every clock edge
// copies the toggle into the acknowledge, which consumes the event.
module fsm1_pulse_capture (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pad_i,
    output logic pend_o
);

    logic tog_q;
    logic ack_q;

    assign pend_o = tog_q ^ ack_q;

    // Toggle only when nothing is pending, so a second edge in the same
    // cycle cannot cancel the first one.
    always_ff @(posedge pad_i or posedge rst_i) begin
        if (rst_i) begin
            tog_q <= 1'b0;
        end else if (!pend_o) begin
            tog_q <= ~tog_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= tog_q;
        end
    end

endmodule

// File: rtl/fsm1_route_core.sv
// Four-state Moore router FSM driven by two pulse-style event inputs.
//   GCLK_Pad  : system clock
//   reset_Pad : asynchronous active-high reset (clears state and pending events)
//   bus       : slave side of fsm1_route_core_if (event pads in, state/output out)
// Events seen since the previous active edge are consumed at the next one;
// the state bits and output1_Pad come straight from the state register.
module fsm1_route_core
    import fsm1_route_core_pkg::*;
#(
    parameter int CLK_EDGE_ONLY = CLK_EDGE_ONLY_DEFAULT
) (
    input  logic               GCLK_Pad,
    input  logic               reset_Pad,
    fsm1_route_core_if.slave   bus
);

    // Nonzero selects the rising edge; zero runs the core on the falling
    // edge for boards that present an inverted clock.
    logic clk_active;
    assign clk_active = (CLK_EDGE_ONLY != 0) ? GCLK_Pad : ~GCLK_Pad;

    logic p1;
    logic p2;

    fsm1_pulse_capture u_cap1 (
        .clk_i  (clk_active),
        .rst_i  (reset_Pad),
        .pad_i  (bus.input1_Pad),
        .pend_o (p1)
    );

    fsm1_pulse_capture u_cap2 (
        .clk_i  (clk_active),
        .rst_i  (reset_Pad),
        .pad_i  (bus.input2_Pad),
        .pend_o (p2)
    );

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clk_active or posedge reset_Pad) begin
        if (reset_Pad) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S0: if (p1) state_d = S1;
            S1: if (p2) state_d = S2;
            S2: begin
                // p1 wins when both events arrive together.
                if (p1)      state_d = S3;
                else if (p2) state_d = S0;
            end
            S3: state_d = S0;
            default: state_d = S0;
        endcase
    end

    always_comb begin
        bus.state_obs0_Pad = state_q[0];
        bus.state_obs1_Pad = state_q[1];
        bus.output1_Pad    = is_s3(state_q);
    end

endmodule

// File: tb/tb_fsm1_route_core.sv
`timescale 1ps/1ps
module tb_fsm1_route_core;

    logic clk;
    logic rst;

    fsm1_route_core_if bus ();

    fsm1_route_core dut (
        .GCLK_Pad  (clk),
        .reset_Pad (rst),
        .bus       (bus.slave)
    );

    // 80 ps period, 2 ps high pulse; first rising edge at 40 ps.
    initial clk = 1'b0;
    always begin
        #40 clk = 1'b1;
        #2  clk = 1'b0;
        #38;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: state as a plain number 0..3 plus pending flags.
    int ms  = 0;
    bit mp1 = 1'b0;
    bit mp2 = 1'b0;

    function automatic int model_next(input int s, input bit a, input bit b);
        if (s == 3) return 0;
        if (s == 0) return a ? 1 : 0;
        if (s == 1) return b ? 2 : 1;
        if (a) return 3;
        if (b) return 0;
        return 2;
    endfunction

    task automatic chk(input string tag, input int exp_st);
        logic [1:0] obs_st;
        logic       exp_out;
        obs_st  = {bus.state_obs1_Pad, bus.state_obs0_Pad};
        exp_out = (exp_st == 3);
        total++;
        assert (obs_st === exp_st[1:0]) else begin
            bad++;
            $error("FAIL %s state obs=%b exp=%b", tag, obs_st, exp_st[1:0]);
        end
        total++;
        assert (bus.output1_Pad === exp_out) else begin
            bad++;
            $error("FAIL %s output1 obs=%b exp=%b", tag, bus.output1_Pad, exp_out);
        end
    endtask

    // Called at posedge+1. Drives the requested pulses mid-cycle, then
    // clocks once and checks against the model.
    task automatic cycle(input bit e1, input bit e2, input bit r, input string tag);
        #19;
        if (r)  rst = 1'b1;
        if (e1) bus.input1_Pad = 1'b1;
        if (e2) bus.input2_Pad = 1'b1;
        #2;
        rst = 1'b0;
        bus.input1_Pad = 1'b0;
        bus.input2_Pad = 1'b0;
        if (r) begin
            ms  = 0;
            mp1 = 1'b0;
            mp2 = 1'b0;
            #1;
            chk({tag, "_async_rst"}, 0);
        end else begin
            mp1 = mp1 | e1;
            mp2 = mp2 | e2;
        end
        @(posedge clk);
        ms  = model_next(ms, mp1, mp2);
        mp1 = 1'b0;
        mp2 = 1'b0;
        #1;
        cyc++;
        chk(tag, ms);
        $display("cyc %0d %s e1=%0d e2=%0d r=%0d state=%b out=%b exp=%0d",
                 cyc, tag, e1, e2, r,
                 {bus.state_obs1_Pad, bus.state_obs0_Pad}, bus.output1_Pad, ms);
    endtask

    initial begin
        rst = 1'b0;
        bus.input1_Pad = 1'b0;
        bus.input2_Pad = 1'b0;
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("power_up_reset", 0);
        $display("reset pulse applied state=%b", {bus.state_obs1_Pad, bus.state_obs0_Pad});

        // Idle clocks do not move the state.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            chk("idle", 0);
            $display("cyc %0d idle state=%b out=%b", cyc,
                     {bus.state_obs1_Pad, bus.state_obs0_Pad}, bus.output1_Pad);
        end

        cycle(1, 0, 0, "s0_in1_to_s1");
        cycle(1, 1, 0, "s1_both_to_s2");
        cycle(1, 0, 0, "s2_in1_to_s3");
        cycle(0, 0, 0, "s3_to_s0");

        cycle(1, 0, 0, "to_s1");
        cycle(1, 1, 1, "coincident_rst");
        cycle(0, 0, 0, "no_retained_evt");

        cycle(1, 0, 0, "to_s1_b");
        cycle(0, 0, 1, "s1_mid_rst");
        cycle(0, 1, 0, "s0_in2_hold");
        cycle(0, 0, 0, "s0_idle_hold");

        cycle(1, 0, 0, "to_s1_c");
        cycle(0, 0, 0, "s1_hold");
        cycle(0, 1, 0, "to_s2");
        cycle(0, 0, 0, "s2_hold");
        cycle(0, 1, 0, "s2_in2_to_s0");

        cycle(1, 0, 0, "to_s1_d");
        cycle(0, 1, 0, "to_s2_b");
        cycle(1, 1, 0, "s2_both_to_s3");
        cycle(1, 1, 0, "s3_uncond_s0");

        for (int i = 0; i < 300; i++) begin
            bit e1;
            bit e2;
            bit r;
            e1 = 1'($urandom_range(0, 1));
            e2 = 1'($urandom_range(0, 1));
            r  = ($urandom_range(0, 15) == 0);
            cycle(e1, e2, r, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute safety net so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fsm1_route_core.md
FSM1_ROUTE_CORE -- requirements
Module: fsm1_route

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, named GCLK_Pad and reset_Pad.
REQ-002 SHALL define parameter CLK_EDGE_ONLY, default 1, meaning all state updates occur on the GCLK_Pad rising edge only.
REQ-003 GCLK_Pad  input  1  system clock; rising edge active; nominal period 80 ps, high pulse 2 ps.
REQ-004 reset_Pad  input  1  asynchronous active-high reset; may arrive as a 2 ps pulse anywhere in the cycle.
REQ-005 input1_Pad  input  1  event input 1; pulse-style, 2 ps wide, arrives between clock edges.
REQ-006 input2_Pad  input  1  event input 2; same pulse style as input1_Pad.
REQ-007 state_obs0_Pad  output  1  state bit 0 (LSB of the current state encoding).
REQ-008 state_obs1_Pad  output  1  state bit 1 (MSB of the current state encoding).
REQ-009 output1_Pad  output  1  FSM output; high while state is S3.

Function
REQ-010 SHALL capture events on input1_Pad and input2_Pad:
- A rising edge since the previous GCLK_Pad rising edge sets pending flag p1 (or p2).
- The pad level at the clock edge is irrelevant.
REQ-011 SHALL consume p1 and p2 at each GCLK_Pad rising edge, then clear them for the next cycle.
- An event arriving in the same cycle as the consuming edge counts toward the following cycle.
REQ-012 SHALL implement a 2-bit Moore FSM with states S0=00, S1=01, S2=10 and S3=11.
REQ-013 SHALL use the following transitions, evaluated at the GCLK_Pad rising edge from (p1, p2):
- S0: p1=1 -> S1; otherwise -> S0.
- S1: p2=1 -> S2, regardless of p1; otherwise -> S1.
- S2: p1=1 -> S3, regardless of p2; p2 only -> S0; neither -> S2.
- S3: unconditionally -> S0.
REQ-014 SHALL drive state_obs1_Pad and state_obs0_Pad directly from the state register.
REQ-015 SHALL drive output1_Pad as a decode of state==S3 with no combinational path from the inputs.
REQ-016 SHALL have a latency of exactly one GCLK_Pad rising edge from an input event to the visible state change.
REQ-017 With no events, SHALL hold the state indefinitely; clocks alone do not advance S0, S1 or S2.

Reset
REQ-018 reset_Pad=1 SHALL immediately, without waiting for a clock, force:
- state to S0;
- state_obs1_Pad and state_obs0_Pad to 00;
- output1_Pad to 0;
- p1 and p2 to 0.
REQ-019 Input events whose rising edge coincides with, or falls within, the reset pulse SHALL be discarded.
REQ-020 After reset deasserts, only new input edges SHALL set p1 or p2.
REQ-021 Reset arriving mid-cycle with pending flags SHALL discard those flags; the next clock edge leaves the state at S0.
REQ-022 Power-up state SHALL be S0 with no pending flags once reset has been asserted at least once.

Structure
REQ-023 A shared package SHALL hold:
- the state typedef (2-bit enum S0..S3);
- the state encoding constants;
- the CLK_EDGE_ONLY default.
REQ-024 Input capture SHALL be one sub-module, fsm1_pulse_capture, instantiated once per event input.
- It uses an edge-clocked toggle/set flag plus a clock-domain clear.
- Its async clear is driven by reset_Pad.
REQ-025 The top level SHALL contain only:
- the two capture instances;
- the state register;
- the next-state logic;
- the output decode.

Verification
REQ-026 Twenty idle clocks after time 0 with no events -> state 00, output1_Pad=0 throughout.
REQ-027 input1 pulse alone mid-cycle, then clock -> state 01; input1+input2 pulses together, then clock -> state 10; output1_Pad=0.
REQ-028 From S2: input1 pulse, then clock -> state 11, output1_Pad=1; the next clock with no events -> state 00, output1_Pad=0.
REQ-029 input1, input2 and reset pulses coincident mid-cycle, then clock -> state 00; no event is retained for the next cycle.
REQ-030 From S1: reset pulse mid-cycle -> state 00 before the next clock edge; input2 alone afterwards, then clock -> stays 00.
REQ-031 From S2: input2 pulse alone, then clock -> state 00.
